// File: rtl/seg_pkg.sv
// Shared types and constants for the six-digit seven-segment display controller.
package seg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONVERT,
        FORMAT,
        HOLD
    } seg_state_e;

    localparam int         SEG_NUM_DIGITS = 6;
    localparam int         SEG_VAL_W      = 20;
    localparam int         SEG_BCD_W      = 4 * SEG_NUM_DIGITS;
    localparam int         SEG_STEPS      = 20;
    localparam logic [4:0] SEG_CODE_BLANK = 5'd20;
    localparam logic [4:0] SEG_DP_OFFSET  = 5'd10;
    localparam logic [19:0] SEG_VAL_MAX   = 20'd999999;

    // Double-dabble correction applied to one BCD nibble before each shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Sequential double-dabble: 20 shift steps turn a 20-bit binary value into six BCD nibbles.
module bin2bcd_seq
    import seg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEG_VAL_W-1:0] value,
    output logic                 done,
    output logic [SEG_BCD_W-1:0] bcd
);

    logic [SEG_VAL_W-1:0] shift_q, shift_d;
    logic [SEG_BCD_W-1:0] bcd_q, bcd_d;
    logic [4:0]           step_q, step_d;
    logic [SEG_BCD_W-1:0] adj;

    // step_q parks at SEG_STEPS while idle, so the converter is inert until started.
    always_comb begin
        shift_d = shift_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        adj     = bcd_q;
        for (int i = 0; i < SEG_NUM_DIGITS; i++) begin
            adj[i*4 +: 4] = dd_adjust(bcd_q[i*4 +: 4]);
        end
        if (start) begin
            shift_d = value;
            bcd_d   = '0;
            step_d  = '0;
        end else if (step_q != 5'(SEG_STEPS)) begin
            bcd_d   = {adj[SEG_BCD_W-2:0], shift_q[SEG_VAL_W-1]};
            shift_d = {shift_q[SEG_VAL_W-2:0], 1'b0};
            step_d  = step_q + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            bcd_q   <= '0;
            step_q  <= 5'(SEG_STEPS);
        end else begin
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
        end
    end

    // High in the cycle whose closing edge performs the final step.
    assign done = (step_q == 5'(SEG_STEPS - 1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Round-robin display controller: arbitrate, convert to BCD, format six digit codes, hold.
// Leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 1000000,
    parameter int          VAL_W       = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [VAL_W-1:0] val0,
    input  logic [VAL_W-1:0] val1,
    input  logic [2:0]       dp0,
    input  logic [2:0]       dp1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             owner,
    output logic [4:0]       digit0,
    output logic [4:0]       digit1,
    output logic [4:0]       digit2,
    output logic [4:0]       digit3,
    output logic [4:0]       digit4,
    output logic [4:0]       digit5
);

    localparam logic [31:0] HOLD_LAST = (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);

    seg_state_e                     state_q, state_d;
    logic                           last_q, last_d;
    logic                           gnt_q, gnt_d;
    logic                           ack0_q, ack0_d, ack1_q, ack1_d;
    logic                           owner_q, owner_d;
    logic [2:0]                     dp_q, dp_d;
    logic [31:0]                    hold_q, hold_d;
    logic [SEG_NUM_DIGITS-1:0][4:0] digits_q, digits_d;
    logic [SEG_NUM_DIGITS-1:0][4:0] fmt_code;
    logic [SEG_VAL_W-1:0]           sel_val, sat_val;
    logic [SEG_BCD_W-1:0]           conv_bcd;
    logic                           conv_done;
    logic                           win1;
`ifdef SEG_LZB_EN
    logic                           lead;
`endif

    assign sel_val = gnt_q ? val1 : val0;
    assign sat_val = (sel_val > SEG_VAL_MAX) ? SEG_VAL_MAX : sel_val;
    // On a tie the port that did not win last time gets the grant.
    assign win1    = req1 && (!req0 || !last_q);

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (state_q == LOAD),
        .value (sat_val),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        fmt_code = '0;
`ifdef SEG_LZB_EN
        lead = 1'b1;
`endif
        for (int i = SEG_NUM_DIGITS - 1; i >= 0; i--) begin
            fmt_code[i] = {1'b0, conv_bcd[i*4 +: 4]} + ((3'(i) == dp_q) ? SEG_DP_OFFSET : 5'd0);
`ifdef SEG_LZB_EN
            if (lead && conv_bcd[i*4 +: 4] == 4'd0 && i != 0 && 3'(i) > dp_q) begin
                fmt_code[i] = SEG_CODE_BLANK;
            end else begin
                lead = 1'b0;
            end
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        owner_d  = owner_q;
        dp_d     = dp_q;
        hold_d   = hold_q;
        digits_d = digits_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d = LOAD;
                    gnt_d   = win1;
                    last_d  = win1;
                    ack0_d  = !win1;
                    ack1_d  = win1;
                end
            end
            LOAD: begin
                dp_d    = gnt_q ? dp1 : dp0;
                state_d = CONVERT;
            end
            CONVERT: begin
                if (conv_done) state_d = FORMAT;
            end
            FORMAT: begin
                digits_d = fmt_code;
                owner_d  = gnt_q;
                hold_d   = '0;
                state_d  = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            owner_q  <= 1'b0;
            dp_q     <= 3'd7;
            hold_q   <= '0;
            digits_q <= {SEG_NUM_DIGITS{SEG_CODE_BLANK}};
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            owner_q  <= owner_d;
            dp_q     <= dp_d;
            hold_q   <= hold_d;
            digits_q <= digits_d;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign busy   = (state_q != IDLE);
    assign owner  = owner_q;
    assign digit0 = digits_q[0];
    assign digit1 = digits_q[1];
    assign digit2 = digits_q[2];
    assign digit3 = digits_q[3];
    assign digit4 = digits_q[4];
    assign digit5 = digits_q[5];

endmodule
